// File: rtl/mfc_mem_pkg.sv
// Shared types and default constants for the wait-stated memory with a
// read-only low region and a function-complete handshake.
package mfc_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DEPTH       = 256;
  localparam int DEF_ROM_WORDS   = 8;
  localparam int DEF_ROM_VALUE   = 1;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int CNT_W           = 4;

  // Index width of the storage array, never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mfc_mem_array.sv
// Single-port storage: synchronous write, combinational read, no reset
// so contents survive a controller reset.
module mfc_mem_array
  import mfc_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int IDX_W  = idx_width(DEF_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [0:DEPTH-1];

  // Commit a write on the clock edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[idx] <= wdata;
    end
  end

  assign rdata = mem_r[idx];

endmodule

// File: rtl/mfc_mem.sv
// Request capture, address decode, wait-state counter and completion FSM
// around the storage array.
module mfc_mem
  import mfc_mem_pkg::*;
#(
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                DEPTH       = DEF_DEPTH,
  parameter int                ROM_WORDS   = DEF_ROM_WORDS,
  parameter logic [DATA_W-1:0] ROM_VALUE   = DATA_W'(DEF_ROM_VALUE),
  parameter int                WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              mfc,
  output logic              err
);

  localparam int               IDX_W      = idx_width(DEPTH);
  localparam logic [ADDR_W:0]  rom_lim_c  = (ADDR_W+1)'(ROM_WORDS);
  localparam logic [ADDR_W:0]  depth_lim_c = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] wait_lim_c = CNT_W'(WAIT_CYCLES);

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic              rw_r, rw_s;
  logic [DATA_W-1:0] din_r, din_s;
  logic [DATA_W-1:0] dout_r, dout_s;
  logic              mfc_r, mfc_s;
  logic              err_r, err_s;
  logic              we_s;
  logic              is_rom_s;
  logic              is_bad_s;
  logic [DATA_W-1:0] rdata_s;

  // Decode works on the captured address, one bit wider so DEPTH == 2**ADDR_W fits.
  assign is_rom_s = ({1'b0, addr_r} < rom_lim_c);
  assign is_bad_s = ({1'b0, addr_r} >= depth_lim_c);

  mfc_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (we_s),
    .idx   (addr_r[IDX_W-1:0]),
    .wdata (din_r),
    .rdata (rdata_s)
  );

  // Next-state, capture and access decisions; the access happens on the DONE-entry edge.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    addr_s  = addr_r;
    rw_s    = rw_r;
    din_s   = din_r;
    dout_s  = dout_r;
    mfc_s   = mfc_r;
    err_s   = err_r;
    we_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        mfc_s = 1'b0;
        err_s = 1'b0;
        if (en) begin
          addr_s  = addr;
          rw_s    = rw;
          din_s   = din;
          cnt_s   = {CNT_W{1'b0}};
          state_s = ST_BUSY;
        end else begin
          cnt_s = {CNT_W{1'b0}};
        end
      end
      ST_BUSY: begin
        if (!en) begin
          // Requester gave up: nothing is written and dout keeps its value.
          state_s = ST_IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == wait_lim_c) begin
          state_s = ST_DONE;
          cnt_s   = {CNT_W{1'b0}};
          mfc_s   = 1'b1;
          if (rw_r) begin
            if (is_rom_s) begin
              dout_s = ROM_VALUE;
              err_s  = 1'b0;
            end else if (is_bad_s) begin
              dout_s = {DATA_W{1'b0}};
              err_s  = 1'b1;
            end else begin
              dout_s = rdata_s;
              err_s  = 1'b0;
            end
          end else begin
            err_s = is_rom_s | is_bad_s;
            we_s  = ~(is_rom_s | is_bad_s);
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (!en) begin
          state_s = ST_IDLE;
          mfc_s   = 1'b0;
          err_s   = 1'b0;
        end else begin
          mfc_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
        mfc_s   = 1'b0;
        err_s   = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      addr_r  <= {ADDR_W{1'b0}};
      rw_r    <= 1'b0;
      din_r   <= {DATA_W{1'b0}};
      dout_r  <= {DATA_W{1'b0}};
      mfc_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      addr_r  <= addr_s;
      rw_r    <= rw_s;
      din_r   <= din_s;
      dout_r  <= dout_s;
      mfc_r   <= mfc_s;
      err_r   <= err_s;
    end
  end

  assign dout = dout_r;
  assign mfc  = mfc_r;
  assign err  = err_r;

endmodule

// File: tb/tb_mfc_mem.sv
// Directed scoreboard bench: two instances (2 and 0 wait states) share
// every input and run the same request sequence.
module tb_mfc_mem;

  logic        clk = 1'b0;
  logic        rst, en, rw;
  logic [15:0] addr, din;
  logic [15:0] dout, dout0;
  logic        mfc, mfc0, err, err0;

  always #5 clk = ~clk;

  mfc_mem #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .rw(rw), .addr(addr), .din(din),
    .dout(dout), .mfc(mfc), .err(err)
  );

  mfc_mem #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .rw(rw), .addr(addr), .din(din),
    .dout(dout0), .mfc(mfc0), .err(err0)
  );

  typedef struct {
    logic [15:0] dout;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] mem_m [0:255];
  logic [15:0] last_rd = 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one completed access; pushes the expected result.
  task automatic push_expect(input logic r, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    if (r) begin
      if (a < 16'd8) begin
        e.dout = 16'h0001; e.err = 1'b0;
      end else if (a < 16'd256) begin
        e.dout = mem_m[a[7:0]]; e.err = 1'b0;
      end else begin
        e.dout = 16'h0000; e.err = 1'b1;
      end
      last_rd = e.dout;
    end else begin
      e.err = (a < 16'd8) || (a >= 16'd256);
      if (!e.err) mem_m[a[7:0]] = d;
      e.dout = last_rd;
    end
    sb.push_back(e);
  endtask

  task automatic do_req(input string tag, input logic r, input logic [15:0] a, input logic [15:0] d);
    int   n, lat, lat0;
    exp_t e;
    push_expect(r, a, d);
    @(negedge clk);
    en = 1'b1; rw = r; addr = a; din = d;
    @(posedge clk); #1;
    rw = ~r; addr = ~a; din = ~d;
    n = 0; lat = 0; lat0 = 0;
    while ((lat == 0 || lat0 == 0) && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (mfc  && lat  == 0) lat  = n;
      if (mfc0 && lat0 == 0) lat0 = n;
    end
    check({tag, "_lat"},  lat,  3);
    check({tag, "_lat0"}, lat0, 1);
    e = sb.pop_front();
    check({tag, "_dout"},  dout,  e.dout);
    check({tag, "_err"},   err,   e.err);
    check({tag, "_dout0"}, dout0, e.dout);
    check({tag, "_err0"},  err0,  e.err);
    @(posedge clk); #1;
    check({tag, "_hold_mfc"}, mfc, 1'b1);
    check({tag, "_hold_err"}, err, e.err);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    check({tag, "_clr_mfc"},  {mfc, mfc0}, 2'b00);
    check({tag, "_clr_err"},  {err, err0}, 2'b00);
    check({tag, "_keep_dout"}, {dout, dout0}, {e.dout, e.dout});
  endtask

  initial begin
    int seen;
    rst = 1'b1; en = 1'b0; rw = 1'b1; addr = 16'h0000; din = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_mfc",  {mfc, mfc0},   2'b00);
    check("rst_err",  {err, err0},   2'b00);
    check("rst_dout", {dout, dout0}, 32'h0000_0000);
    rst = 1'b0;
    @(negedge clk);

    do_req("wr20",  1'b0, 16'd20,  16'hBEEF);
    do_req("rd20",  1'b1, 16'd20,  16'h0000);
    do_req("wr5",   1'b0, 16'd5,   16'h1234);
    do_req("rd5",   1'b1, 16'd5,   16'h0000);
    do_req("wr44",  1'b0, 16'd44,  16'h4444);
    do_req("rd300", 1'b1, 16'd300, 16'h0000);
    do_req("wr300", 1'b0, 16'd300, 16'h9999);
    do_req("rd44",  1'b1, 16'd44,  16'h0000);
    do_req("wr255", 1'b0, 16'd255, 16'h00FF);
    do_req("rd255", 1'b1, 16'd255, 16'h0000);
    do_req("rd256", 1'b1, 16'd256, 16'h0000);
    do_req("wr0",   1'b0, 16'd0,   16'h7777);
    do_req("rd7",   1'b1, 16'd7,   16'h0000);
    do_req("wr8",   1'b0, 16'd8,   16'h0808);
    do_req("rd8",   1'b1, 16'd8,   16'h0000);

    // Abort: en drops before the first BUSY edge of a write to 30.
    do_req("wr30", 1'b0, 16'd30, 16'hAAAA);
    @(negedge clk);
    en = 1'b1; rw = 1'b0; addr = 16'd30; din = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (mfc || mfc0) seen++;
    end
    check("abort_mfc",  seen, 0);
    check("abort_dout", {dout, dout0}, {last_rd, last_rd});
    do_req("rd30", 1'b1, 16'd30, 16'h0000);

    // Reset in the middle of a write to 40.
    do_req("wr40", 1'b0, 16'd40, 16'h2222);
    do_req("rd20b", 1'b1, 16'd20, 16'h0000);
    @(negedge clk);
    en = 1'b1; rw = 1'b0; addr = 16'd40; din = 16'h1111;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_mfc",  {mfc, mfc0},   2'b00);
    check("midrst_err",  {err, err0},   2'b00);
    check("midrst_dout", {dout, dout0}, 32'h0000_0000);
    last_rd = 16'h0000;
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_req("rd40", 1'b1, 16'd40, 16'h0000);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
